// File: rtl/sha256_pad_pkg.sv
// Shared constants and state encoding for the streaming SHA-256 padder.
package sha256_pad_pkg;

    localparam int BLOCK_BITS  = 512;
    localparam int BLOCK_BYTES = 64;
    localparam int LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        FILL,
        PAD,
        EMIT,
        LEN_ONLY,
        MARK_LEN
    } pad_state_e;

endpackage

// File: rtl/sha256_pad_insert.sv
// Combinational pad insertion: keeps bytes below q, optionally marks q,
// zero fills the rest and drops in the length field when it still fits.
module sha256_pad_insert
    import sha256_pad_pkg::*;
(
    input  logic [BLOCK_BITS-1:0] buffer,
    input  logic [6:0]            q,
    input  logic                  mark,
    input  logic [63:0]           length,
    output logic [BLOCK_BITS-1:0] padded
);

    always_comb begin
        padded = buffer;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (mark && (7'(i) == q)) begin
                padded[BLOCK_BITS-1-8*i -: 8] = PAD_BYTE;
            end else if (7'(i) >= q) begin
                padded[BLOCK_BITS-1-8*i -: 8] = 8'h00;
            end
            // Length only fits when the marker landed below byte 56.
            if ((q < 7'(LEN_OFFSET)) && (i >= LEN_OFFSET)) begin
                padded[BLOCK_BITS-1-8*i -: 8] =
                    length[63-8*(i-LEN_OFFSET) -: 8];
            end
        end
    end

endmodule

// File: rtl/sha256_block_padder.sv
// Streaming SHA-256 padder: packs bytes big-endian into 512-bit blocks,
// appends marker, zero fill and bit length, and emits blocks one at a time.
module sha256_block_padder
    import sha256_pad_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [BLOCK_BITS-1:0] blk_data,
    output logic                  blk_last,
    output logic [7:0]            blk_index,
    output logic [63:0]           msg_len_bits
);

    pad_state_e state_q;
    pad_state_e state_d;
    pad_state_e follow_q;

    logic [LEN_W-1:0]      byte_cnt;
    logic [6:0]            q_reg;
    logic [BLOCK_BITS-1:0] buffer;
    logic [63:0]           len_field;
    logic [5:0]            pos;
    logic [8:0]            wr_msb;
    logic                  in_fire;
    logic                  blk_fire;

    logic [BLOCK_BITS-1:0] ins_buf;
    logic [6:0]            ins_q;
    logic                  ins_mark;
    logic [BLOCK_BITS-1:0] ins_out;

    assign in_ready  = (state_q == FILL) && !reset;
    assign blk_valid = (state_q == EMIT);
    assign blk_data  = buffer;
    assign in_fire   = in_valid && in_ready;
    assign blk_fire  = blk_valid && blk_ready;
    assign pos       = byte_cnt[5:0];
    assign wr_msb    = {~pos, 3'b111};
    assign len_field = {{(64-LEN_W-3){1'b0}}, byte_cnt, 3'b000};

    sha256_pad_insert u_insert (
        .buffer (ins_buf),
        .q      (ins_q),
        .mark   (ins_mark),
        .length (len_field),
        .padded (ins_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ins_buf  = buffer;
        ins_q    = q_reg;
        ins_mark = 1'b1;
        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (in_last) begin
                        state_d = PAD;
                    end else if (pos == 6'd63) begin
                        state_d = EMIT;
                    end
                end
            end
            PAD: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (blk_fire) begin
                    state_d = blk_last ? FILL : follow_q;
                end
            end
            LEN_ONLY: begin
                ins_buf  = '0;
                ins_q    = 7'd0;
                ins_mark = 1'b0;
                state_d  = EMIT;
            end
            MARK_LEN: begin
                ins_buf = '0;
                ins_q   = 7'd0;
                state_d = EMIT;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt     <= '0;
            q_reg        <= '0;
            buffer       <= '0;
            blk_last     <= 1'b0;
            blk_index    <= '0;
            msg_len_bits <= '0;
            follow_q     <= FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_fire) begin
                        buffer[wr_msb -: 8] <= in_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (in_last) begin
                            q_reg <= {1'b0, pos} + 7'd1;
                        end
                    end
                end
                PAD: begin
                    buffer <= ins_out;
                    if (q_reg < 7'(LEN_OFFSET)) begin
                        blk_last     <= 1'b1;
                        msg_len_bits <= len_field;
                        follow_q     <= FILL;
                    end else begin
                        blk_last <= 1'b0;
                        follow_q <= (q_reg == 7'd64) ? MARK_LEN : LEN_ONLY;
                    end
                end
                EMIT: begin
                    if (blk_fire) begin
                        follow_q <= FILL;
                        if (blk_last) begin
                            byte_cnt  <= '0;
                            blk_index <= '0;
                            blk_last  <= 1'b0;
                        end else begin
                            blk_index <= blk_index + 8'd1;
                        end
                    end
                end
                LEN_ONLY, MARK_LEN: begin
                    buffer       <= ins_out;
                    blk_last     <= 1'b1;
                    msg_len_bits <= len_field;
                end
                default: begin
                    follow_q <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Randomized bench for sha256_block_padder against a byte-queue padding model.
module tb_sha256_block_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_last;
    logic [7:0]   blk_index;
    logic [63:0]  msg_len_bits;

    int checks = 0;
    int failures = 0;

    logic [7:0] msg_q[$];
    logic [7:0] pad_q[$];

    sha256_block_padder #(.LEN_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_last     (blk_last),
        .blk_index    (blk_index),
        .msg_len_bits (msg_len_bits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic make_msg(input int n, input bit abc);
        msg_q.delete();
        for (int i = 0; i < n; i++) begin
            msg_q.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
        end
    endtask

    // Message, 0x80, zeros to 56 mod 64, then 64-bit big-endian bit count.
    task automatic build_ref();
        logic [63:0] bits;
        pad_q = msg_q;
        pad_q.push_back(8'h80);
        while ((pad_q.size() % 64) != 56) pad_q.push_back(8'h00);
        bits = 64'(msg_q.size()) * 64'd8;
        for (int i = 0; i < 8; i++) pad_q.push_back(bits[63-8*i -: 8]);
    endtask

    function automatic logic [511:0] ref_blk(input int b);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[511-8*i -: 8] = pad_q[64*b+i];
        return r;
    endfunction

    task automatic run_msg(input int stall, input bit gaps);
        int n;
        int nb;
        int idx;
        int got;
        int cyc;
        int hold;
        int exp_rise;
        bit prev_v;
        bit acc;
        bit xfer;
        build_ref();
        n = msg_q.size();
        nb = pad_q.size() / 64;
        idx = 0;
        got = 0;
        cyc = 0;
        hold = 0;
        exp_rise = -1;
        prev_v = 1'b0;
        while (got < nb && cyc < 20000) begin
            @(negedge clk);
            in_valid = (idx < n) && (!gaps || ($urandom_range(0, 3) != 0));
            in_data  = (idx < n) ? msg_q[idx] : 8'h00;
            in_last  = (idx == n - 1);
            blk_ready = (hold >= stall);
            acc  = in_valid && in_ready;
            xfer = 1'b0;
            if (blk_valid && !prev_v && exp_rise >= 0) begin
                chk("latency", 512'(cyc), 512'(exp_rise));
                exp_rise = -1;
            end
            if (blk_valid) begin
                chk("rdy_in_emit", 512'(in_ready), 512'(0));
                chk("data", blk_data, ref_blk(got));
                chk("index", 512'(blk_index), 512'(got % 256));
                chk("last", 512'(blk_last), 512'(got == nb - 1));
                if (got == nb - 1)
                    chk("len", 512'(msg_len_bits), 512'(64'(n) * 64'd8));
                if (blk_ready) begin
                    got++;
                    hold = 0;
                    xfer = 1'b1;
                end else begin
                    hold++;
                end
            end
            if (xfer && got < nb && idx == n) exp_rise = cyc + 2;
            if (acc) begin
                if (in_last) exp_rise = cyc + 2;
                else if ((idx % 64) == 63) exp_rise = cyc + 1;
                idx++;
            end
            prev_v = blk_valid;
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        blk_ready = 1'b0;
        chk("timeout", 512'(cyc < 20000), 512'(1));
        chk("bytes", 512'(idx), 512'(n));
        chk("idle_valid", 512'(blk_valid), 512'(0));
        chk("idle_ready", 512'(in_ready), 512'(1));
    endtask

    task automatic feed_raw(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = msg_q[i];
            in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 512'(blk_valid), 512'(0));
        chk("rst_ready", 512'(in_ready), 512'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("r_in_ready", 512'(in_ready), 512'(0));
        chk("r_blk_valid", 512'(blk_valid), 512'(0));
        chk("r_blk_last", 512'(blk_last), 512'(0));
        chk("r_blk_index", 512'(blk_index), 512'(0));
        chk("r_blk_data", blk_data, 512'(0));
        chk("r_len", 512'(msg_len_bits), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 512'(in_ready), 512'(1));

        make_msg(3, 1'b1);
        run_msg(0, 1'b0);
        make_msg(55, 1'b0);
        run_msg(0, 1'b0);
        make_msg(56, 1'b0);
        run_msg(1, 1'b0);
        make_msg(64, 1'b0);
        run_msg(0, 1'b0);
        make_msg(80, 1'b0);
        run_msg(5, 1'b0);
        make_msg(119, 1'b0);
        run_msg(2, 1'b1);
        make_msg(120, 1'b0);
        run_msg(0, 1'b1);
        make_msg(128, 1'b0);
        run_msg(3, 1'b1);
        make_msg(1, 1'b0);
        run_msg(0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            make_msg($urandom_range(1, 200), 1'b0);
            run_msg($urandom_range(0, 3), 1'b1);
        end

        make_msg(40, 1'b0);
        feed_raw(20);
        pulse_reset();
        make_msg(3, 1'b1);
        run_msg(0, 1'b0);

        make_msg(64, 1'b0);
        feed_raw(64);
        @(posedge clk);
        #1;
        chk("full_blk_valid", 512'(blk_valid), 512'(1));
        @(negedge clk);
        pulse_reset();
        make_msg(3, 1'b1);
        run_msg(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
